regfile_sb: RTL

//  Parametrised multi-read-port register file with async reset, write-to-read bypass
//  and a per-register pending-write scoreboard.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 74 +++++++
 rtl/regfile_sb.sv | 81 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, typedefs and constants for the ID-stage register file and its scoreboard.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int ZERO_ADDR      = 0;

    typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one pending bit per register, a running pending count,
// a sticky double-issue flag and per-read-port busy flags for the hazard unit.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     stall,
    output logic [ADDR_W:0]          pend_cnt,
    output logic                     dbl_iss
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = ADDR_W + 1;

    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic             iss_ok;
    logic             same_addr;
    logic             inc;
    logic             dec;
    logic             dbl_hit;

    always_comb begin
        same_addr = wr_en && (wr_addr == iss_addr);
        iss_ok    = iss_en && !((ZERO_REG != 0) && (iss_addr == ADDR_W'(ZERO_ADDR)));
        // Count only real 0->1 and 1->0 transitions so pend_cnt equals popcount(pend).
        inc       = iss_ok && !pend[iss_addr];
        dec       = wr_en && pend[wr_addr] && !(iss_ok && (wr_addr == iss_addr));
        dbl_hit   = iss_ok && pend[iss_addr] && !same_addr;
        pend_nxt  = pend;
        for (int i = 0; i < DEPTH; i++) begin
            if (iss_ok && (iss_addr == ADDR_W'(i))) begin
                pend_nxt[i] = 1'b1;
            end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                pend_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            pend_cnt <= '0;
            dbl_iss  <= 1'b0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= pend_cnt + CW'(inc) - CW'(dec);
            if (dbl_hit) begin
                dbl_iss <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
        logic [ADDR_W-1:0] a;
        assign a          = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_busy[k] = pend[a] && !((BYPASS != 0) && wr_en && (wr_addr == a));
    end

    assign stall = |rd_busy;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-to-read bypass and a pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     stall,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [ADDR_W:0]          pend_cnt,
    output logic                     dbl_iss,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;

    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(ZERO_ADDR)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Zero register has priority over bypass so a stray write to r0 never leaks through.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[k*ADDR_W +: ADDR_W];
        always_comb begin
            if ((ZERO_REG != 0) && (a == ADDR_W'(ZERO_ADDR))) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
            end else if ((BYPASS != 0) && wr_en && (wr_addr == a)) begin
                rd_data[k*DATA_W +: DATA_W] = wr_data;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = mem[a];
            end
        end
    end

    assign dbg_data = mem[dbg_addr];

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .stall    (stall),
        .pend_cnt (pend_cnt),
        .dbl_iss  (dbl_iss)
    );

endmodule
